// File: rtl/trng_seq.sv
// ---------------------------------------------------------------------------
// trng_seq
//   Sequencing controller for the TRNG generator core. Walks the core through
//   seed load, warm-up and run phases, decimates the raw bit stream by gating
//   the core step enable, packs sampled bits MSB-first into words and offers
//   them on a valid/ready port.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   en         level: 1 = generate, 0 = stop (go IDLE)
//   reseed     one-cycle pulse: restart from LOAD (ignored in IDLE)
//   gen_bit    raw bit from the core
//   load_en    core is in the seed-load phase
//   init_en    core is in the warm-up phase
//   run_en     core is in the run phase (also asserted while holding a word)
//   core_ce    core step enable
//   out_data   packed output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data
//   busy       sequencer is not idle
// ---------------------------------------------------------------------------
module trng_seq #(
   parameter int LOAD_CYCLES = 17,
   parameter int INIT_CYCLES = 36,
   parameter int DECIM       = 5,
   parameter int WORD_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              reseed,
   input  logic              gen_bit,
   output logic              load_en,
   output logic              init_en,
   output logic              run_en,
   output logic              core_ce,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int PH_MAX = (LOAD_CYCLES > INIT_CYCLES) ? LOAD_CYCLES : INIT_CYCLES;
   localparam int CNT_W  = $clog2(PH_MAX + 1);
   localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int BCNT_W = $clog2(WORD_W + 1);

   localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DEC_LAST  = DCNT_W'(DECIM - 1);
   localparam logic [BCNT_W-1:0] WORD_LAST = BCNT_W'(WORD_W - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_INIT = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic [2:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DCNT_W-1:0] dcnt;
   logic [BCNT_W-1:0] bcnt;
   logic [WORD_W-1:0] sreg;
   logic [WORD_W-1:0] oreg;

   logic              tick;
   logic              word_done;
   logic              xfer;
   logic [WORD_W-1:0] sreg_sh;

   always_comb begin
      tick      = (state == S_RUN) && (dcnt == DEC_LAST);
      word_done = tick && (bcnt == WORD_LAST);
      xfer      = out_valid & out_ready;
      sreg_sh   = {sreg[WORD_W-2:0], gen_bit};
   end

   assign load_en  = (state == S_LOAD);
   assign init_en  = (state == S_INIT);
   assign run_en   = (state == S_RUN) || (state == S_HOLD);
   assign core_ce  = load_en | init_en | tick;
   assign busy     = (state != S_IDLE);
   assign out_data = oreg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         dcnt      <= '0;
         bcnt      <= '0;
         sreg      <= '0;
         oreg      <= '0;
         out_valid <= 1'b0;
      end else begin
         // A consumed word clears valid unless a new word is loaded below.
         if (xfer)
            out_valid <= 1'b0;

         if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
            dcnt  <= '0;
            bcnt  <= '0;
            sreg  <= '0;
         end else if (reseed && (state != S_IDLE)) begin
            state <= S_LOAD;
            cnt   <= '0;
            dcnt  <= '0;
            bcnt  <= '0;
            sreg  <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_LOAD;
                  cnt   <= '0;
               end
               S_LOAD: begin
                  if (cnt == LOAD_LAST) begin
                     state <= S_INIT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_INIT: begin
                  if (cnt == INIT_LAST) begin
                     state <= S_RUN;
                     cnt   <= '0;
                     dcnt  <= '0;
                     bcnt  <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_RUN: begin
                  if (tick) begin
                     dcnt <= '0;
                     sreg <= sreg_sh;
                     if (word_done && (!out_valid || out_ready)) begin
                        oreg      <= sreg_sh;
                        out_valid <= 1'b1;
                        bcnt      <= '0;
                     end else begin
                        bcnt <= bcnt + 1'b1;
                        // Output slot still occupied: park the full word in sreg.
                        if (word_done)
                           state <= S_HOLD;
                     end
                  end else begin
                     dcnt <= dcnt + 1'b1;
                  end
               end
               S_HOLD: begin
                  // dcnt stays frozen so decimation phase resumes where it stopped.
                  if (xfer) begin
                     oreg      <= sreg;
                     out_valid <= 1'b1;
                     bcnt      <= '0;
                     state     <= S_RUN;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/trng_seq.md
# trng_seq

Sequencing controller for the TRNG generator core. It runs the core through seed load, warm-up and run phases, and gates the core's clock-enable to decimate its output stream. It packs the decimated bits into words and presents them on a valid/ready port. It sits between the generator core (load/init/run/step controls, raw bit in) and the consumer bus.

## Interface
Parameters:
- LOAD_CYCLES, 17, cycles spent in LOAD (seed shift-in)
- INIT_CYCLES, 36, cycles spent in INIT (warm-up, output discarded)
- DECIM, 5, RUN cycles per sampled bit (≥1)
- WORD_W, 32, output word width (≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  level; high = generate, low = stop
- reseed  in  1  one-cycle pulse; restart from LOAD
- gen_bit  in  1  raw output bit of the core
- load_en  out  1  core in LOAD phase
- init_en  out  1  core in INIT phase
- run_en  out  1  core in RUN phase
- core_ce  out  1  core step enable
- out_data  out  WORD_W  packed word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, INIT, RUN, HOLD. Phase counter (cnt), decimation counter (dcnt), bit counter (bcnt), shift register (sreg), output register (oreg + out_valid).
- IDLE: all phase outputs 0, core_ce 0. en=1 → LOAD with cnt=0.
- LOAD: load_en=1, core_ce=1 every cycle; after LOAD_CYCLES cycles → INIT, cnt=0.
- INIT: init_en=1, core_ce=1 every cycle; after INIT_CYCLES cycles → RUN, dcnt=0, bcnt=0.
- RUN: run_en=1. core_ce=1 only when dcnt==DECIM-1; dcnt then wraps to 0. On every edge with core_ce=1, gen_bit shifts into sreg LSB (shift left, so the first bit ends in the MSB) and bcnt increments.
- Word complete (bcnt reaches WORD_W on a tick): if out_valid=0, or out_ready=1 in the same cycle, then sreg → oreg, out_valid=1, bcnt=0.
- Otherwise → HOLD. The full word stays in sreg.
- HOLD: run_en=1, core_ce=0, dcnt frozen. When out_ready & out_valid: sreg → oreg, bcnt=0, return to RUN. dcnt resumes, so the next tick comes DECIM-dcnt cycles later.
- Output handshake: a transfer happens on any edge with out_valid & out_ready. out_valid clears unless a new word loads in the same cycle. out_data is stable while out_valid=1 and out_ready=0.
- reseed=1 in LOAD/INIT/RUN/HOLD: next state LOAD, cnt=0, bcnt=0, dcnt=0, and sreg bits are discarded. oreg and out_valid are kept. reseed in IDLE is ignored.
- en=0 in any non-IDLE state: next state IDLE, and sreg bits are discarded. oreg and out_valid are kept until consumed.
- Priority: rst > en=0 > reseed > normal transitions.
- DECIM=1: core_ce=1 every RUN cycle.

## Timing
- Reset: state IDLE, all outputs 0, including out_data, out_valid and busy. All counters 0.
- Let edge E be the one where en is first seen high in IDLE.
  - load_en is high from the cycle after E for exactly LOAD_CYCLES cycles.
  - init_en is then high for exactly INIT_CYCLES cycles.
  - run_en rises LOAD_CYCLES+INIT_CYCLES cycles after E.
- The first RUN core_ce pulse occurs in the DECIM-th RUN cycle. Later pulses are every DECIM cycles, with no gaps while not in HOLD.
- Without backpressure, the first out_valid rises the cycle after the edge that captures the WORD_W-th bit, i.e. WORD_W·DECIM cycles into RUN.
- Word throughput: one word per WORD_W·DECIM cycles.
- Latency from out_ready to the HOLD→RUN transition is one edge. No bit is lost or duplicated across a HOLD.

## Test plan
- Reset/idle: rst=0 for 2 cycles with en=1 → all outputs 0. Release rst → load_en=1 for 17 cycles, then init_en=1 for 36 cycles, then run_en=1. Check 17/36 exactly.
- Decimation: in RUN with defaults, core_ce pattern over 10 cycles is 0,0,0,0,1,0,0,0,0,1. core_ce is high every cycle in LOAD/INIT.
- Packing: drive gen_bit=1 on tick k for odd k only (k=1..32), with out_ready=1 → out_valid rises 160 cycles into RUN, out_data=32'hAAAAAAAA, out_valid is a 1-cycle pulse.
- Backpressure: hold out_ready=0 → first word held stable, second word completes → HOLD with core_ce=0 and no ticks. Raise out_ready for 1 cycle → second word appears next cycle, RUN resumes. Bit sequence is contiguous across both words.
- Reseed mid-run: reseed pulse at bcnt=10 with out_valid=1 → next cycle load_en=1, the 10 partial bits are discarded, and the pending word is still valid and unchanged. The full 17/36 sequence repeats.
- Stop and corner cases:
  - en=0 during HOLD → IDLE next cycle, busy=0, oreg retained until out_ready.
  - Reseed and en=0 in the same cycle → IDLE.
  - Parametrization WORD_W=8, DECIM=1 → one word every 8 RUN cycles.
